// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with debounced push-button duty control.
// One shared counter drives every channel; shadow duties are applied only at period boundaries.
module pwm_multichannel #(
  parameter  int CHANNELS     = 4,
  parameter  int CNT_WIDTH    = 8,
  parameter  int PERIOD       = 100,
  parameter  int STEP         = 10,
  parameter  int DUTY_INIT    = 50,
  parameter  int DEBOUNCE_DIV = 250000,
  localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          swt_increase,
  input  logic                          swt_decrease,
  input  logic                          swt_select,
  input  logic                          mode,
  output logic [CHANNELS-1:0]           PWM_OUT,
  output logic [CHANNELS*CNT_WIDTH-1:0] DUTY_CYCLE,
  output logic [SEL_W-1:0]              SEL_CH
);

  localparam int                  DB_W     = $clog2(DEBOUNCE_DIV);
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_C = CNT_WIDTH'(PERIOD);
  localparam logic [CNT_WIDTH:0]   PERIOD_X = (CNT_WIDTH + 1)'(PERIOD);
  localparam logic [CNT_WIDTH:0]   STEP_X   = (CNT_WIDTH + 1)'(STEP);
  localparam logic [CNT_WIDTH-1:0] DUTY_RST = CNT_WIDTH'(DUTY_INIT);
  localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(CHANNELS - 1);

  typedef enum logic {DIR_UP, DIR_DOWN}       dir_e;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;

  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
  logic [2:0]           btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic                 sample_en;
  logic [2:0]           press;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CNT_WIDTH-1:0] duty_sh_q  [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_sh_d  [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_act_q [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_act_d [CHANNELS];
  logic [CNT_WIDTH-1:0] sel_duty, new_duty;
  logic [CNT_WIDTH:0]   inc_sum;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  dir_e                 dir_q, dir_d;
  mode_e                mode_q, mode_d;
  logic                 bnd;
  logic [CHANNELS-1:0]  pwm_q, pwm_d;

  // Buttons are sampled at a slow tick; a press is a rising edge between two consecutive samples.
  always_comb begin
    sample_en = (db_cnt_q == DB_LAST);
    db_cnt_d  = sample_en ? '0 : db_cnt_q + DB_W'(1);
    btn_s1_d  = sample_en ? {swt_select, swt_decrease, swt_increase} : btn_s1_q;
    btn_s2_d  = sample_en ? btn_s1_q : btn_s2_q;
    press     = btn_s1_q & ~btn_s2_q & {3{sample_en}};
  end

  always_comb begin
    sel_duty = duty_sh_q[0];
    for (int unsigned i = 0; i < CHANNELS; i++)
      if (SEL_W'(i) == sel_q) sel_duty = duty_sh_q[i];
    inc_sum  = {1'b0, sel_duty} + STEP_X;
    new_duty = sel_duty;
    if (press[0] && !press[1])
      new_duty = (inc_sum > PERIOD_X) ? PERIOD_C : inc_sum[CNT_WIDTH-1:0];
    else if (press[1] && !press[0])
      new_duty = ({1'b0, sel_duty} >= STEP_X) ? sel_duty - STEP_X[CNT_WIDTH-1:0] : '0;
    duty_sh_d = duty_sh_q;
    for (int unsigned i = 0; i < CHANNELS; i++)
      if (SEL_W'(i) == sel_q) duty_sh_d[i] = new_duty;
    sel_d = sel_q;
    if (press[2]) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
  end

  // Every boundary leaves the counter at 0 counting up, which also makes a mode switch restart cleanly.
  always_comb begin
    bnd        = (mode_q == MODE_EDGE) ? (cnt_q == CNT_LAST)
                                       : (dir_q == DIR_DOWN && cnt_q == '0);
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    duty_act_d = duty_act_q;
    if (bnd) begin
      cnt_d      = '0;
      dir_d      = DIR_UP;
      mode_d     = mode ? MODE_CENTER : MODE_EDGE;
      duty_act_d = duty_sh_q;
    end else if (mode_q == MODE_EDGE) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == CNT_LAST) dir_d = DIR_DOWN;
      else                   cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (mode_q == MODE_CENTER)
        pwm_d[i] = ({1'b0, cnt_q} >= (PERIOD_X - {1'b0, duty_act_q[i]}));
      else
        pwm_d[i] = (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sel_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= DUTY_RST;
        duty_act_q[i] <= DUTY_RST;
      end
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= MODE_EDGE;
      pwm_q  <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      sel_q      <= sel_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      pwm_q      <= pwm_d;
    end
  end

  always_comb begin
    DUTY_CYCLE = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      DUTY_CYCLE[i*CNT_WIDTH +: CNT_WIDTH] = duty_sh_q[i];
  end

  assign PWM_OUT = pwm_q;
  assign SEL_CH  = sel_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel: 2 channels, 10-step period, unit step, fast debounce tick.
module tb_pwm_multichannel;
  localparam int CH = 2, CW = 4, PER = 10, STP = 1, DINIT = 5, DBD = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic swt_inc = 1'b0, swt_dec = 1'b0, swt_sel = 1'b0, mode = 1'b0;
  logic [CH-1:0]    pwm_o;
  logic [CH*CW-1:0] duty_o;
  logic [0:0]       sel_o;

  int passed = 0, total = 0;
  int cyc;
  logic [31:0] pwm_q[$];
  logic [31:0] reg_q[$];
  logic [31:0] want;

  pwm_multichannel #(
    .CHANNELS(CH), .CNT_WIDTH(CW), .PERIOD(PER), .STEP(STP),
    .DUTY_INIT(DINIT), .DEBOUNCE_DIV(DBD)
  ) dut (
    .clk(clk), .rst(rst), .swt_increase(swt_inc), .swt_decrease(swt_dec),
    .swt_select(swt_sel), .mode(mode), .PWM_OUT(pwm_o), .DUTY_CYCLE(duty_o), .SEL_CH(sel_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges since reset release; the counter phase follows from it.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  // Expected output after edge e for a steady duty d; center mode starts at the edge after c0.
  function automatic logic pwm_model(input int e, input int d, input bit center, input int c0);
    int m, v;
    if (!center) begin
      v = (e - 1) % PER;
      return v < d;
    end
    m = (e - c0 - 1) % (2 * PER);
    v = (m < PER) ? m : (2 * PER - 1 - m);
    return v >= PER - d;
  endfunction

  task automatic press(input int which, input int hold);
    swt_inc = (which == 0 || which == 3);
    swt_dec = (which == 1 || which == 3);
    swt_sel = (which == 2);
    repeat (hold) @(negedge clk);
    swt_inc = 1'b0; swt_dec = 1'b0; swt_sel = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    reg_q.push_back(32'h0); reg_q.push_back(32'h55); reg_q.push_back(32'h0);
    repeat (2) @(negedge clk);
    want = reg_q.pop_front(); total++;
    if (32'(pwm_o) !== want) $display("FAIL reset_pwm got=%h want=%h", pwm_o, want); else passed++;
    want = reg_q.pop_front(); total++;
    if (32'(duty_o) !== want) $display("FAIL reset_duty got=%h want=%h", duty_o, want); else passed++;
    want = reg_q.pop_front(); total++;
    if (32'(sel_o) !== want) $display("FAIL reset_sel got=%h want=%h", sel_o, want); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_edge_default;
    int hi0 = 0, hi1 = 0;
    for (int k = 0; k < 30; k++) begin
      want = '0;
      want[0] = pwm_model(cyc + 1, 5, 1'b0, 0);
      want[1] = pwm_model(cyc + 1, 5, 1'b0, 0);
      pwm_q.push_back(want);
      @(negedge clk);
      want = pwm_q.pop_front(); total++;
      if (pwm_o !== want[1:0]) $display("FAIL edge_default cyc=%0d got=%b want=%b", cyc, pwm_o, want[1:0]);
      else passed++;
      if (cyc > 10 && cyc <= 20) begin hi0 += int'(pwm_o[0]); hi1 += int'(pwm_o[1]); end
    end
    total++;
    if (hi0 != 5 || hi1 != 5) $display("FAIL edge_high_count got=%0d,%0d want=5,5", hi0, hi1); else passed++;
  endtask

  task automatic test_increase_hold;
    int cp = 0, changes = 0, e, d0;
    logic [CH*CW-1:0] prev;
    reg_q.push_back(32'd1); reg_q.push_back(32'h56);
    prev = duty_o;
    swt_inc = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 40) swt_inc = 1'b0;
      e  = cyc + 1;
      d0 = (cp > 0 && e >= (cp / PER + 1) * PER + 1) ? 6 : 5;
      want = '0;
      want[0] = pwm_model(e, d0, 1'b0, 0);
      want[1] = pwm_model(e, 5, 1'b0, 0);
      pwm_q.push_back(want);
      @(negedge clk);
      want = pwm_q.pop_front(); total++;
      if (pwm_o !== want[1:0]) $display("FAIL hold_pwm cyc=%0d got=%b want=%b", cyc, pwm_o, want[1:0]);
      else passed++;
      if (duty_o !== prev) begin
        changes++;
        if (cp == 0) cp = cyc;
        prev = duty_o;
      end
    end
    want = reg_q.pop_front(); total++;
    if (changes !== int'(want)) $display("FAIL hold_pulses got=%0d want=%0d", changes, want); else passed++;
    want = reg_q.pop_front(); total++;
    if (32'(duty_o) !== want) $display("FAIL hold_duty got=%h want=%h", duty_o, want); else passed++;
  endtask

  task automatic test_saturation;
    int d = 6;
    for (int k = 0; k < 6; k++) begin
      d = (d + 1 > PER) ? PER : d + 1;
      reg_q.push_back(32'(5 * 16 + d));
      press(0, 10);
      want = reg_q.pop_front(); total++;
      if (32'(duty_o) !== want) $display("FAIL sat_inc_%0d got=%h want=%h", k, duty_o, want); else passed++;
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      want = '0;
      want[0] = pwm_model(cyc + 1, d, 1'b0, 0);
      want[1] = pwm_model(cyc + 1, 5, 1'b0, 0);
      pwm_q.push_back(want);
      @(negedge clk);
      want = pwm_q.pop_front(); total++;
      if (pwm_o !== want[1:0]) $display("FAIL sat_full cyc=%0d got=%b want=%b", cyc, pwm_o, want[1:0]);
      else passed++;
    end
    for (int k = 0; k < 11; k++) begin
      d = (d >= STP) ? d - STP : 0;
      reg_q.push_back(32'(5 * 16 + d));
      press(1, 10);
      want = reg_q.pop_front(); total++;
      if (32'(duty_o) !== want) $display("FAIL sat_dec_%0d got=%h want=%h", k, duty_o, want); else passed++;
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      want = '0;
      want[0] = pwm_model(cyc + 1, d, 1'b0, 0);
      want[1] = pwm_model(cyc + 1, 5, 1'b0, 0);
      pwm_q.push_back(want);
      @(negedge clk);
      want = pwm_q.pop_front(); total++;
      if (pwm_o !== want[1:0]) $display("FAIL sat_zero cyc=%0d got=%b want=%b", cyc, pwm_o, want[1:0]);
      else passed++;
    end
  endtask

  task automatic test_select;
    reg_q.push_back(32'd1);
    press(2, 10);
    want = reg_q.pop_front(); total++;
    if (32'(sel_o) !== want) $display("FAIL sel_first got=%h want=%h", sel_o, want); else passed++;
    reg_q.push_back(32'h60);
    press(0, 10);
    want = reg_q.pop_front(); total++;
    if (32'(duty_o) !== want) $display("FAIL sel_inc_ch1 got=%h want=%h", duty_o, want); else passed++;
    reg_q.push_back(32'd0);
    press(2, 10);
    want = reg_q.pop_front(); total++;
    if (32'(sel_o) !== want) $display("FAIL sel_wrap got=%h want=%h", sel_o, want); else passed++;
    reg_q.push_back(32'd1);
    press(2, 10);
    want = reg_q.pop_front(); total++;
    if (32'(sel_o) !== want) $display("FAIL sel_again got=%h want=%h", sel_o, want); else passed++;
  endtask

  task automatic test_center;
    int c0, e, hi0 = 0, hi1 = 0;
    bit found = 1'b0;
    repeat (3) press(1, 10);
    press(2, 10);
    repeat (3) press(0, 10);
    reg_q.push_back(32'h33); reg_q.push_back(32'd0);
    want = reg_q.pop_front(); total++;
    if (32'(duty_o) !== want) $display("FAIL center_duty got=%h want=%h", duty_o, want); else passed++;
    want = reg_q.pop_front(); total++;
    if (32'(sel_o) !== want) $display("FAIL center_sel got=%h want=%h", sel_o, want); else passed++;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 20 && !found; k++) begin
      if (cyc % PER == 4) found = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!found) $display("FAIL center_align got=timeout want=mid-period"); else passed++;
    mode = 1'b1;
    c0 = (cyc / PER + 1) * PER;
    for (int k = 0; k < 60; k++) begin
      e = cyc + 1;
      want = '0;
      want[0] = pwm_model(e, 3, e > c0, c0);
      want[1] = pwm_model(e, 3, e > c0, c0);
      pwm_q.push_back(want);
      @(negedge clk);
      want = pwm_q.pop_front(); total++;
      if (pwm_o !== want[1:0]) $display("FAIL center_pwm cyc=%0d got=%b want=%b", cyc, pwm_o, want[1:0]);
      else passed++;
      if (cyc > c0 && cyc <= c0 + 2 * PER) begin hi0 += int'(pwm_o[0]); hi1 += int'(pwm_o[1]); end
    end
    total++;
    if (hi0 != 6 || hi1 != 6) $display("FAIL center_high_count got=%0d,%0d want=6,6", hi0, hi1); else passed++;
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (pwm_o[0] === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL mid_high got=timeout want=pwm high"); else passed++;
    reg_q.push_back(32'h0); reg_q.push_back(32'h55); reg_q.push_back(32'h0);
    rst = 1'b1;
    #1;
    want = reg_q.pop_front(); total++;
    if (32'(pwm_o) !== want) $display("FAIL mid_reset_pwm got=%h want=%h", pwm_o, want); else passed++;
    want = reg_q.pop_front(); total++;
    if (32'(duty_o) !== want) $display("FAIL mid_reset_duty got=%h want=%h", duty_o, want); else passed++;
    want = reg_q.pop_front(); total++;
    if (32'(sel_o) !== want) $display("FAIL mid_reset_sel got=%h want=%h", sel_o, want); else passed++;
    mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reg_q.push_back(32'h55);
    press(3, 10);
    want = reg_q.pop_front(); total++;
    if (32'(duty_o) !== want) $display("FAIL inc_dec_same got=%h want=%h", duty_o, want); else passed++;
    for (int k = 0; k < 20; k++) begin
      want = '0;
      want[0] = pwm_model(cyc + 1, 5, 1'b0, 0);
      want[1] = pwm_model(cyc + 1, 5, 1'b0, 0);
      pwm_q.push_back(want);
      @(negedge clk);
      want = pwm_q.pop_front(); total++;
      if (pwm_o !== want[1:0]) $display("FAIL post_reset_pwm cyc=%0d got=%b want=%b", cyc, pwm_o, want[1:0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_edge_default();
    test_increase_hold();
    test_saturation();
    test_select();
    test_center();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
